// File: rtl/or_nway_pipe_if.sv
// ---------------------------------------------------------------------------
// or_nway_pipe_if
//   Handshake bundle for the N-way reduction unit.
//   master : producer/consumer side (drives the input beat, out_ready, clear)
//   slave  : the reduction unit itself
//   Signals:
//     in_valid / in_ready   input beat handshake
//     a [WIDTH]             word to reduce
//     op [2]                00 OR, 01 AND, 10 XOR, 11 NOR
//     out_valid / out_ready output beat handshake
//     out                   reduction result
//     sticky                set once any transferred result was 1
//     clear                 synchronous clear of sticky
// ---------------------------------------------------------------------------
interface or_nway_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic             out;
  logic             sticky;
  logic             clear;

  modport master (
    output in_valid, a, op, out_ready, clear,
    input  in_ready, out_valid, out, sticky
  );

  modport slave (
    input  in_valid, a, op, out_ready, clear,
    output in_ready, out_valid, out, sticky
  );
endinterface

// File: rtl/or_nway_pipe.sv
// ---------------------------------------------------------------------------
// or_nway_pipe
//   Pipelined N-way reduction of a WIDTH-bit word to one bit. The operation
//   (OR/AND/XOR/NOR) is chosen per beat and travels down the pipe with its
//   data, so mixed ops may be in flight. A sticky flag remembers whether any
//   transferred result was 1.
//   Parameters:
//     WIDTH  word width, 2..64; tree depth L = clog2(WIDTH)
//     PIPE   1: register after every tree level (latency L)
//            0: whole tree combinational, one output register (latency 1)
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset (control state only)
//     bus    or_nway_pipe_if slave modport
// ---------------------------------------------------------------------------
module or_nway_pipe #(
  parameter int WIDTH = 16,
  parameter bit PIPE  = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  or_nway_pipe_if.slave bus
);

  localparam int L   = $clog2(WIDTH);
  localparam int N   = 1 << L;
  localparam int S   = PIPE ? L : 1;
  localparam int LPS = PIPE ? 1 : L;  // tree levels evaluated inside one stage

  localparam logic [1:0] OP_OR  = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  // Unused leaves take the identity of the op so they cannot affect the result.
  function automatic logic [N-1:0] pad(input logic [WIDTH-1:0] v, input logic [1:0] opc);
    logic [N-1:0] r;
    r = {N{opc == OP_AND}};
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  // One tree level: pairs (2i, 2i+1) fold into bit i; upper half becomes 0.
  // NOR folds as OR; the inversion happens only at the last stage.
  function automatic logic [N-1:0] lvl(input logic [N-1:0] v, input logic [1:0] opc);
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N / 2; i++) begin
      case (opc)
        OP_AND:  r[i] = v[2*i] & v[2*i+1];
        OP_XOR:  r[i] = v[2*i] ^ v[2*i+1];
        default: r[i] = v[2*i] | v[2*i+1];
      endcase
    end
    return r;
  endfunction

  function automatic logic [N-1:0] step(input logic [N-1:0] v, input logic [1:0] opc);
    logic [N-1:0] t;
    t = v;
    for (int j = 0; j < LPS; j++) t = lvl(t, opc);
    return t;
  endfunction

  function automatic logic fin(input logic [N-1:0] v, input logic [1:0] opc);
    logic [N-1:0] t;
    t = step(v, opc);
    return t[0] ^ (opc == OP_NOR);
  endfunction

  logic [S-1:0] vld_p;
  logic         out_q;
  logic         sticky_q;
  logic         stall;
  logic         adv;

  // The whole pipe freezes while the output beat waits; no bubble collapsing.
  assign stall         = vld_p[S-1] & ~bus.out_ready;
  assign adv           = ~stall;
  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_p[S-1];
  assign bus.out       = out_q;
  assign bus.sticky    = sticky_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
    end else if (adv) begin
      vld_p <= (vld_p << 1) | S'(bus.in_valid);
    end
  end

  // Clear wins over a coincident set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else if (bus.clear) begin
      sticky_q <= 1'b0;
    end else if (vld_p[S-1] & bus.out_ready & out_q) begin
      sticky_q <= 1'b1;
    end
  end

  for (genvar k = 0; k < S; k++) begin : g_stg
    logic [N-1:0] din;
    logic [1:0]   oin;

    // stage k input: padded word for the first stage, previous register otherwise
    if (k == 0) begin : g_src
      assign din = pad(bus.a, bus.op);
      assign oin = bus.op;
    end else begin : g_src
      assign din = g_stg[k-1].g_reg.dat_p;
      assign oin = g_stg[k-1].g_reg.op_p;
    end

    if (k == S - 1) begin : g_out
      // stage k -> output register (final fold, NOR inversion)
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_q <= 1'b0;
        end else if (adv) begin
          out_q <= fin(din, oin);
        end
      end
    end else begin : g_reg
      logic [N-1:0] dat_p;
      logic [1:0]   op_p;
      // stage k -> stage k+1 register (data not reset)
      always_ff @(posedge clk) begin
        if (adv) begin
          dat_p <= step(din, oin);
          op_p  <= oin;
        end
      end
    end
  end

endmodule

// File: tb/tb_or_nway_pipe.sv
// ---------------------------------------------------------------------------
// tb_or_nway_pipe
//   Three instances share one stimulus stream: 16-bit pipelined (main),
//   13-bit pipelined (leaf padding) and 16-bit with PIPE=0 (latency 1).
//   Each instance has an in-order scoreboard fed with hand-computed (or
//   model-computed for the random burst) expected results, plus directed
//   cycle-exact checks of latency, in_ready, sticky and reset behaviour.
// ---------------------------------------------------------------------------
module tb_or_nway_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic        clear;
  logic [15:0] a16;
  logic [1:0]  op;
  logic        e16;
  logic        e13;

  int n_chk;
  int n_fail;

  logic q16[$];
  logic q13[$];
  logic q0[$];

  logic        acc;
  int          sent;
  logic [15:0] a_v [6];
  logic [1:0]  op_v[6];
  logic        e_v [6];
  logic [15:0] p_a [4];
  logic [1:0]  p_op[4];
  logic        p_e16[4];
  logic        p_e13[4];

  or_nway_pipe_if #(.WIDTH(16)) if16 ();
  or_nway_pipe_if #(.WIDTH(13)) if13 ();
  or_nway_pipe_if #(.WIDTH(16)) if0 ();

  assign if16.in_valid  = in_valid;
  assign if16.a         = a16;
  assign if16.op        = op;
  assign if16.out_ready = out_ready;
  assign if16.clear     = clear;
  assign if13.in_valid  = in_valid;
  assign if13.a         = a16[12:0];
  assign if13.op        = op;
  assign if13.out_ready = out_ready;
  assign if13.clear     = clear;
  assign if0.in_valid   = in_valid;
  assign if0.a          = a16;
  assign if0.op         = op;
  assign if0.out_ready  = out_ready;
  assign if0.clear      = clear;

  or_nway_pipe #(.WIDTH(16), .PIPE(1'b1)) u16 (.clk(clk), .rst_n(rst_n), .bus(if16));
  or_nway_pipe #(.WIDTH(13), .PIPE(1'b1)) u13 (.clk(clk), .rst_n(rst_n), .bus(if13));
  or_nway_pipe #(.WIDTH(16), .PIPE(1'b0)) u0  (.clk(clk), .rst_n(rst_n), .bus(if0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Straight bitwise reduction over the low w bits, used for random beats.
  function automatic logic model(input logic [15:0] v, input logic [1:0] o, input int w);
    logic [15:0] m;
    m = (w >= 16) ? 16'hFFFF : 16'((32'd1 << w) - 1);
    case (o)
      2'b00:   return |(v & m);
      2'b01:   return &(v | ~m);
      2'b10:   return ^(v & m);
      default: return ~|(v & m);
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [15:0] av, input logic [1:0] ov, input logic x16, input logic x13);
    in_valid = 1'b1;
    a16      = av;
    op       = ov;
    e16      = x16;
    e13      = x13;
  endtask

  // Scoreboards: output transfer pops, input transfer pushes.
  always @(negedge clk) begin
    if (rst_n) begin
      if (if16.out_valid && out_ready) begin
        if (q16.size() == 0) chk("sb16_extra", 1, 0);
        else chk("sb16", if16.out, q16.pop_front());
      end
      if (in_valid && if16.in_ready) q16.push_back(e16);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (if13.out_valid && out_ready) begin
        if (q13.size() == 0) chk("sb13_extra", 1, 0);
        else chk("sb13", if13.out, q13.pop_front());
      end
      if (in_valid && if13.in_ready) q13.push_back(e13);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (if0.out_valid && out_ready) begin
        if (q0.size() == 0) chk("sb0_extra", 1, 0);
        else chk("sb0", if0.out, q0.pop_front());
      end
      if (in_valid && if0.in_ready) q0.push_back(e16);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    a16       = '0;
    op        = 2'b00;
    out_ready = 1'b1;
    clear     = 1'b0;
    e16       = 1'b0;
    e13       = 1'b0;
    acc       = 1'b0;
    sent      = 0;
    a_v   = '{16'h0000, 16'h0100, 16'hFFFF, 16'hFFFE, 16'h0007, 16'h0000};
    op_v  = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b11};
    e_v   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    p_a   = '{16'h1FFF, 16'h1FFE, 16'h1000, 16'hE000};
    p_op  = '{2'b01, 2'b01, 2'b00, 2'b00};
    p_e16 = '{1'b0, 1'b0, 1'b1, 1'b1};
    p_e13 = '{1'b1, 1'b0, 1'b1, 1'b0};

    // ---- reset state ----
    #2 rst_n = 1'b0;
    #1;
    chk("rst_vld16", if16.out_valid, 0);
    chk("rst_vld0", if0.out_valid, 0);
    chk("rst_out16", if16.out, 0);
    chk("rst_sticky16", if16.sticky, 0);
    chk("rst_rdy16", if16.in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step();

    // ---- ops, back-to-back, latency 4 (main) and 1 (PIPE=0) ----
    for (int c = 0; c < 12; c++) begin
      step();
      if (c < 6) beat(a_v[c], op_v[c], e_v[c], e_v[c]);
      else in_valid = 1'b0;
      @(negedge clk);
      if (c >= 4 && c < 10) begin
        chk("ops_vld16", if16.out_valid, 1);
        chk("ops_out16", if16.out, e_v[c-4]);
      end else begin
        chk("ops_idle16", if16.out_valid, 0);
      end
      if (c >= 1 && c < 7) begin
        chk("ops_vld0", if0.out_valid, 1);
        chk("ops_out0", if0.out, e_v[c-1]);
      end else begin
        chk("ops_idle0", if0.out_valid, 0);
      end
      chk("ops_rdy16", if16.in_ready, 1);
    end

    // ---- leaf padding (13-bit instance) ----
    for (int c = 0; c < 10; c++) begin
      step();
      if (c < 4) beat(p_a[c], p_op[c], p_e16[c], p_e13[c]);
      else in_valid = 1'b0;
      @(negedge clk);
      if (c >= 4 && c < 8) begin
        chk("pad_vld13", if13.out_valid, 1);
        chk("pad_out13", if13.out, p_e13[c-4]);
        chk("pad_out16", if16.out, p_e16[c-4]);
      end else begin
        chk("pad_idle13", if13.out_valid, 0);
      end
    end

    // ---- reset mid-stream with 3 beats in flight ----
    for (int c = 0; c < 4; c++) begin
      step();
      if (c < 3) beat(16'h0001, 2'b00, 1'b1, 1'b1);
      else in_valid = 1'b0;
    end
    #2;
    chk("pre_rst_sticky16", if16.sticky, 1);
    chk("pre_rst_vld0", if0.out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld16", if16.out_valid, 0);
    chk("mid_rst_sticky16", if16.sticky, 0);
    chk("mid_rst_out16", if16.out, 0);
    chk("mid_rst_vld0", if0.out_valid, 0);
    chk("mid_rst_sticky0", if0.sticky, 0);
    q16.delete();
    q13.delete();
    q0.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_rdy16", if16.in_ready, 1);
    chk("post_rst_rdy0", if0.in_ready, 1);
    for (int c = 0; c < 6; c++) begin
      step();
      if (c == 0) beat(16'h8000, 2'b00, 1'b1, 1'b0);
      else in_valid = 1'b0;
      @(negedge clk);
      if (c == 4) begin
        chk("post_rst_vld16", if16.out_valid, 1);
        chk("post_rst_out16", if16.out, 1);
      end else begin
        chk("post_rst_idle16", if16.out_valid, 0);
      end
    end

    // ---- sticky: clear, set, clear-vs-set, stalled beat ----
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    @(negedge clk);
    chk("clr_sticky16", if16.sticky, 0);
    chk("clr_sticky0", if0.sticky, 0);

    for (int c = 0; c < 6; c++) begin
      step();
      if (c == 0) beat(16'h0001, 2'b00, 1'b1, 1'b1);
      else in_valid = 1'b0;
      @(negedge clk);
      if (c == 1) chk("set_sticky0_pre", if0.sticky, 0);
      if (c == 2) chk("set_sticky0", if0.sticky, 1);
      if (c == 4) begin
        chk("set_vld16", if16.out_valid, 1);
        chk("set_sticky16_pre", if16.sticky, 0);
      end
      if (c == 5) chk("set_sticky16", if16.sticky, 1);
    end

    for (int c = 0; c < 7; c++) begin
      step();
      if (c == 0) beat(16'h0010, 2'b10, 1'b1, 1'b1);
      else in_valid = 1'b0;
      if (c == 4) clear = 1'b1;
      if (c == 5) clear = 1'b0;
      @(negedge clk);
      if (c == 4) chk("clrset_sticky16_pre", if16.sticky, 1);
      if (c == 5) chk("clrset_sticky16", if16.sticky, 0);
      if (c == 6) chk("clrset_sticky16_hold", if16.sticky, 0);
    end

    for (int c = 0; c < 10; c++) begin
      step();
      if (c == 0) beat(16'h4000, 2'b00, 1'b1, 1'b0);
      else in_valid = 1'b0;
      if (c == 3) out_ready = 1'b0;
      if (c == 7) out_ready = 1'b1;
      @(negedge clk);
      if (c == 3) chk("stall_rdy16_empty", if16.in_ready, 1);
      if (c == 4) chk("stall_rdy0_empty", if0.in_ready, 1);
      if (c >= 4 && c <= 6) begin
        chk("stall_vld16", if16.out_valid, 1);
        chk("stall_rdy16", if16.in_ready, 0);
        chk("stall_sticky16", if16.sticky, 0);
      end
      if (c == 7) begin
        chk("stall_rel_rdy16", if16.in_ready, 1);
        chk("stall_rel_sticky16", if16.sticky, 0);
      end
      if (c == 8) chk("stall_done_sticky16", if16.sticky, 1);
    end

    // ---- backpressure with 8 random beats, out_ready low on cycles 5-7 ----
    acc  = 1'b0;
    sent = 0;
    for (int c = 0; c < 24; c++) begin
      step();
      if (c == 5) out_ready = 1'b0;
      if (c == 8) out_ready = 1'b1;
      if (acc) sent++;
      if (sent < 8) begin
        if (c == 0 || acc) begin
          a16 = 16'($urandom);
          op  = 2'($urandom_range(0, 3));
          e16 = model(a16, op, 16);
          e13 = model(a16, op, 13);
        end
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      acc = in_valid && if16.in_ready;
      if (c <= 12) begin
        chk("bp_rdy16", if16.in_ready, (c >= 5 && c <= 7) ? 0 : 1);
        chk("bp_rdy0", if0.in_ready, (c >= 5 && c <= 7) ? 0 : 1);
      end
    end
    chk("bp_sent", sent, 8);

    // ---- drain: nothing lost, nothing left ----
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (8) step();
    @(negedge clk);
    chk("drain_q16", q16.size(), 0);
    chk("drain_q13", q13.size(), 0);
    chk("drain_q0", q0.size(), 0);
    chk("drain_vld16", if16.out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
